interval_sequencer: RTL and testbench
=====================================

Name: interval_sequencer

Overview:
- Controller for the countdown timer datapath.
- Holds a small program of interval presets (hh:mm:ss) and loads them into the timer one after another.
- Starts and pauses the timer, raises a timed alarm at each expiry, and can loop the program.
- Sits between the switch/debouncer inputs and the timer core; all logic runs on the 1 Hz tick.

Parameters:
NUM_SLOTS, 4, number of interval preset slots (power of 2, 2..8)
SLOT_W, 2, slot index width = log2(NUM_SLOTS)
ALARM_SECS, 3, alarm duration in clk_1Hz cycles after each expiry (1..15)

Ports:
clk_1Hz  in  1  1 Hz system tick clock
resetn  in  1  asynchronous, active-low reset
prog_en  in  1  switch; 1 = programming mode
prog_wr  in  1  debounced 1-cycle pulse; writes the preset fields into slot prog_slot
prog_slot  in  SLOT_W  slot index for writes
prog_hour  in  5  preset hours
prog_min  in  6  preset minutes
prog_sec  in  6  preset seconds
run  in  1  switch; 1 = run/resume, 0 = pause
abort  in  1  debounced pulse; cancels the sequence
loop_en  in  1  switch; 1 = restart from the first valid slot after the last one
tmr_zero  in  1  timer core reports 00:00:00 while counting
tmr_load  out  1  1-cycle preset load strobe to the timer
tmr_hour  out  5  preset hours to the timer
tmr_min  out  6  preset minutes to the timer
tmr_sec  out  6  preset seconds to the timer
tmr_run  out  1  timer count enable
alarm  out  1  buzzer/LED drive
cur_slot  out  SLOT_W  slot currently loaded
slot_valid  out  NUM_SLOTS  per-slot valid flags
round_cnt  out  8  completed loop rounds, saturating
busy  out  1  high in LOAD, RUN, PAUSE and ALARM
seq_done  out  1  high in DONE

Behaviour:
- Reset (async): state IDLE, slot memory zero, slot_valid=0, all outputs 0, alarm counter 0, round_cnt 0.
- Slot write: accepted only in IDLE or PROGRAM when prog_en & prog_wr.
  - Values are clamped: hour>12 → 12; min>59 → 59; sec>59 → 59.
  - slot_valid[i] is set iff the clamped value is nonzero; writing 00:00:00 clears the valid flag.
  - Writes in any other state are ignored.
- Output registration: all outputs are registered; tmr_hour/min/sec hold the last loaded preset until reset.
- States:
  - IDLE:
    - prog_en → PROGRAM.
    - Else run & |slot_valid → LOAD, with cur_slot = lowest valid slot and round_cnt cleared.
    - run with no valid slot: stay in IDLE.
  - PROGRAM: !prog_en → IDLE. run is ignored.
  - LOAD:
    - Exactly one cycle: tmr_load=1, tmr_*=slot[cur_slot], tmr_run=0.
    - Next state RUN; tmr_zero is ignored in this cycle.
  - RUN: tmr_run=1. Priority abort > tmr_zero > !run.
    - abort → IDLE.
    - tmr_zero → ALARM, alarm counter = ALARM_SECS.
    - !run → PAUSE.
  - PAUSE: tmr_run=0. abort → IDLE; run → RUN.
  - ALARM:
    - alarm=1 and tmr_run=0; the counter decrements each cycle.
    - abort → IDLE immediately.
    - When the counter reaches 1, select the next valid slot above cur_slot:
      - Found → LOAD with that slot.
      - Else if loop_en → LOAD with the lowest valid slot, and round_cnt+1 (saturates at 255).
      - Else → DONE.
    - The run switch is ignored during ALARM.
  - DONE: seq_done=1. !run or abort → IDLE.
- Timing: alarm is high for exactly ALARM_SECS cycles. Latency from tmr_zero to the next tmr_load is ALARM_SECS+1 cycles.
- Abort from any busy state → IDLE next cycle: tmr_run=0, alarm=0, slot memory retained.
- slot_valid changes are impossible while busy, so the next-slot search never sees a modified program.
- prog_en asserted while busy has no effect until the sequencer returns to IDLE.

Decomposition:
- Shared package (timer_pkg):
  - State encoding localparams (IDLE, PROGRAM, LOAD, RUN, PAUSE, ALARM, DONE).
  - Limits MAX_HOUR=12 and MAX_MINSEC=59.
  - Field widths HOUR_W=5 and MS_W=6.
- Sub-module slot_store: register file with clamping write, valid flags and a combinational "next valid above index" / "lowest valid" priority search.
- FSM, alarm counter and round counter live in the top module.

Test Plan:
- Program slot0=00:00:05, slot2=00:01:00, loop_en=0, run=1 → LOAD with tmr_sec=5; on tmr_zero, alarm high 3 cycles; LOAD slot2 (tmr_min=1); after its alarm → DONE with seq_done=1; run=0 → IDLE.
- Write slot1 with hour=20, min=63, sec=0 → stored as 12:59:00 and slot_valid[1]=1; rewrite 00:00:00 → slot_valid[1]=0.
- loop_en=1, single valid slot3 → after each alarm, LOAD slot3 again and round_cnt increments 1, 2, 3; force 256 rounds → round_cnt holds at 255.
- In RUN, set run=0 → PAUSE with tmr_run=0 next cycle; run=1 → RUN; assert abort together with tmr_zero → IDLE, no alarm.
- run=1 with all slots invalid → stays IDLE with tmr_load never asserted; prog_wr during RUN → slot contents unchanged.
- Deassert resetn mid-ALARM → alarm, tmr_run and slot_valid all 0 immediately, state IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types, widths and limits for the interval sequencer and its slot store.
package timer_pkg;

  localparam int unsigned HOUR_W     = 5;
  localparam int unsigned MS_W       = 6;
  localparam int unsigned ALARM_W    = 4;
  localparam int unsigned ROUND_W    = 8;
  localparam int unsigned MAX_HOUR   = 12;
  localparam int unsigned MAX_MINSEC = 59;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PROGRAM = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RUN     = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_ALARM   = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MS_W-1:0]   min;
    logic [MS_W-1:0]   sec;
  } preset_t;

  // Saturate each field to its wall-clock limit.
  function automatic preset_t clamp_preset(input logic [HOUR_W-1:0] h,
                                           input logic [MS_W-1:0]   m,
                                           input logic [MS_W-1:0]   s);
    preset_t p;
    p.hour = (h > HOUR_W'(MAX_HOUR))   ? HOUR_W'(MAX_HOUR)   : h;
    p.min  = (m > MS_W'(MAX_MINSEC))   ? MS_W'(MAX_MINSEC)   : m;
    p.sec  = (s > MS_W'(MAX_MINSEC))   ? MS_W'(MAX_MINSEC)   : s;
    return p;
  endfunction

endpackage

// File: rtl/slot_store.sv
// Preset register file with clamping writes, per-slot valid flags and
// priority searches for the lowest valid slot and the next valid slot above an index.
module slot_store
  import timer_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SLOT_W    = 2
) (
  input  logic                 clk_1Hz,
  input  logic                 resetn,
  input  logic                 wr_en,
  input  logic [SLOT_W-1:0]    wr_idx,
  input  logic [HOUR_W-1:0]    wr_hour,
  input  logic [MS_W-1:0]      wr_min,
  input  logic [MS_W-1:0]      wr_sec,
  input  logic [SLOT_W-1:0]    rd_idx,
  input  logic [SLOT_W-1:0]    search_idx,
  output preset_t              rd_data,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic                 found_above,
  output logic [SLOT_W-1:0]    above_idx,
  output logic [SLOT_W-1:0]    lowest_idx
);

  preset_t [NUM_SLOTS-1:0] mem_q, mem_d;
  logic    [NUM_SLOTS-1:0] valid_q, valid_d;
  preset_t                 wr_clamped;

  always_ff @(posedge clk_1Hz or negedge resetn) begin
    if (!resetn) begin
      mem_q   <= '0;
      valid_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
    end
  end

  // An all-zero preset is stored but marks the slot empty.
  always_comb begin
    mem_d      = mem_q;
    valid_d    = valid_q;
    wr_clamped = clamp_preset(wr_hour, wr_min, wr_sec);
    if (wr_en) begin
      mem_d[wr_idx]   = wr_clamped;
      valid_d[wr_idx] = |wr_clamped;
    end
  end

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    found_above = 1'b0;
    above_idx   = '0;
    lowest_idx  = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (valid_q[i]) begin
        lowest_idx = SLOT_W'(i);
        if (SLOT_W'(i) > search_idx) begin
          found_above = 1'b1;
          above_idx   = SLOT_W'(i);
        end
      end
    end
  end

  assign rd_data    = mem_q[rd_idx];
  assign slot_valid = valid_q;

endmodule

// File: rtl/interval_sequencer.sv
// Sequences programmed interval presets into the countdown timer core,
// with pause/abort, a timed alarm at each expiry and optional looping.
module interval_sequencer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned SLOT_W     = 2,
  parameter int unsigned ALARM_SECS = 3
) (
  input  logic                 clk_1Hz,
  input  logic                 resetn,
  input  logic                 prog_en,
  input  logic                 prog_wr,
  input  logic [SLOT_W-1:0]    prog_slot,
  input  logic [HOUR_W-1:0]    prog_hour,
  input  logic [MS_W-1:0]      prog_min,
  input  logic [MS_W-1:0]      prog_sec,
  input  logic                 run,
  input  logic                 abort,
  input  logic                 loop_en,
  input  logic                 tmr_zero,
  output logic                 tmr_load,
  output logic [HOUR_W-1:0]    tmr_hour,
  output logic [MS_W-1:0]      tmr_min,
  output logic [MS_W-1:0]      tmr_sec,
  output logic                 tmr_run,
  output logic                 alarm,
  output logic [SLOT_W-1:0]    cur_slot,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic [ROUND_W-1:0]   round_cnt,
  output logic                 busy,
  output logic                 seq_done
);

  state_e               state_q, state_d;
  logic [SLOT_W-1:0]    cur_slot_q, cur_slot_d;
  logic [ROUND_W-1:0]   round_cnt_q, round_cnt_d;
  logic [ALARM_W-1:0]   alarm_cnt_q, alarm_cnt_d;
  preset_t              preset_q, preset_d;
  logic                 tmr_load_q, tmr_load_d;
  logic                 tmr_run_q, tmr_run_d;
  logic                 alarm_q, alarm_d;
  logic                 busy_q, busy_d;
  logic                 seq_done_q, seq_done_d;

  logic                 wr_en;
  preset_t              rd_data;
  logic                 found_above;
  logic [SLOT_W-1:0]    above_idx, lowest_idx;

  // Program edits only while idle so a running sequence never sees them.
  assign wr_en = prog_en & prog_wr & ((state_q == ST_IDLE) | (state_q == ST_PROGRAM));

  slot_store #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_slot_store (
    .clk_1Hz     (clk_1Hz),
    .resetn      (resetn),
    .wr_en       (wr_en),
    .wr_idx      (prog_slot),
    .wr_hour     (prog_hour),
    .wr_min      (prog_min),
    .wr_sec      (prog_sec),
    .rd_idx      (cur_slot_d),
    .search_idx  (cur_slot_q),
    .rd_data     (rd_data),
    .slot_valid  (slot_valid),
    .found_above (found_above),
    .above_idx   (above_idx),
    .lowest_idx  (lowest_idx)
  );

  always_ff @(posedge clk_1Hz or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cur_slot_q  <= '0;
      round_cnt_q <= '0;
      alarm_cnt_q <= '0;
      preset_q    <= '0;
      tmr_load_q  <= 1'b0;
      tmr_run_q   <= 1'b0;
      alarm_q     <= 1'b0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_slot_q  <= cur_slot_d;
      round_cnt_q <= round_cnt_d;
      alarm_cnt_q <= alarm_cnt_d;
      preset_q    <= preset_d;
      tmr_load_q  <= tmr_load_d;
      tmr_run_q   <= tmr_run_d;
      alarm_q     <= alarm_d;
      busy_q      <= busy_d;
      seq_done_q  <= seq_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_slot_d  = cur_slot_q;
    round_cnt_d = round_cnt_q;
    alarm_cnt_d = alarm_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (prog_en) begin
          state_d = ST_PROGRAM;
        end else if (run && (|slot_valid)) begin
          state_d     = ST_LOAD;
          cur_slot_d  = lowest_idx;
          round_cnt_d = '0;
        end
      end
      ST_PROGRAM: if (!prog_en) state_d = ST_IDLE;
      ST_LOAD:    state_d = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          state_d     = ST_ALARM;
          alarm_cnt_d = ALARM_W'(ALARM_SECS);
        end else if (!run) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (abort)    state_d = ST_IDLE;
        else if (run) state_d = ST_RUN;
      end
      ST_ALARM: begin
        if (abort) begin
          state_d     = ST_IDLE;
          alarm_cnt_d = '0;
        end else if (alarm_cnt_q <= ALARM_W'(1)) begin
          alarm_cnt_d = '0;
          if (found_above) begin
            state_d    = ST_LOAD;
            cur_slot_d = above_idx;
          end else if (loop_en) begin
            state_d    = ST_LOAD;
            cur_slot_d = lowest_idx;
            if (round_cnt_q != '1) round_cnt_d = round_cnt_q + ROUND_W'(1);
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          alarm_cnt_d = alarm_cnt_q - ALARM_W'(1);
        end
      end
      ST_DONE: if (!run || abort) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so the registered copies line up with it.
  always_comb begin
    tmr_load_d = (state_d == ST_LOAD);
    tmr_run_d  = (state_d == ST_RUN);
    alarm_d    = (state_d == ST_ALARM);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_RUN) ||
                 (state_d == ST_PAUSE) || (state_d == ST_ALARM);
    seq_done_d = (state_d == ST_DONE);
    preset_d   = preset_q;
    if (state_d == ST_LOAD) preset_d = rd_data;
  end

  assign tmr_load  = tmr_load_q;
  assign tmr_run   = tmr_run_q;
  assign alarm     = alarm_q;
  assign busy      = busy_q;
  assign seq_done  = seq_done_q;
  assign cur_slot  = cur_slot_q;
  assign round_cnt = round_cnt_q;
  assign tmr_hour  = preset_q.hour;
  assign tmr_min   = preset_q.min;
  assign tmr_sec   = preset_q.sec;

endmodule

// File: tb/tb_interval_sequencer.sv
// Scoreboard bench for interval_sequencer: each driven cycle queues the expected
// output vector, which is popped and compared just after the next clock edge.
module tb_interval_sequencer;
  import timer_pkg::*;

  localparam int unsigned NUM_SLOTS  = 4;
  localparam int unsigned SLOT_W     = 2;
  localparam int unsigned ALARM_SECS = 3;

  logic                 clk_1Hz = 1'b0;
  logic                 resetn  = 1'b0;
  logic                 prog_en = 1'b0, prog_wr = 1'b0;
  logic [SLOT_W-1:0]    prog_slot = '0;
  logic [HOUR_W-1:0]    prog_hour = '0;
  logic [MS_W-1:0]      prog_min = '0, prog_sec = '0;
  logic                 run = 1'b0, abort = 1'b0, loop_en = 1'b0, tmr_zero = 1'b0;
  logic                 tmr_load, tmr_run, alarm, busy, seq_done;
  logic [HOUR_W-1:0]    tmr_hour;
  logic [MS_W-1:0]      tmr_min, tmr_sec;
  logic [SLOT_W-1:0]    cur_slot;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [7:0]           round_cnt;

  interval_sequencer #(
    .NUM_SLOTS  (NUM_SLOTS),
    .SLOT_W     (SLOT_W),
    .ALARM_SECS (ALARM_SECS)
  ) dut (
    .clk_1Hz    (clk_1Hz),
    .resetn     (resetn),
    .prog_en    (prog_en),
    .prog_wr    (prog_wr),
    .prog_slot  (prog_slot),
    .prog_hour  (prog_hour),
    .prog_min   (prog_min),
    .prog_sec   (prog_sec),
    .run        (run),
    .abort      (abort),
    .loop_en    (loop_en),
    .tmr_zero   (tmr_zero),
    .tmr_load   (tmr_load),
    .tmr_hour   (tmr_hour),
    .tmr_min    (tmr_min),
    .tmr_sec    (tmr_sec),
    .tmr_run    (tmr_run),
    .alarm      (alarm),
    .cur_slot   (cur_slot),
    .slot_valid (slot_valid),
    .round_cnt  (round_cnt),
    .busy       (busy),
    .seq_done   (seq_done)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  // Vector layout: {load, run, alarm, busy, done, slot[2], hour[5], min[6], sec[6], round[8], valid[4]}
  logic [35:0] obs;
  assign obs = {tmr_load, tmr_run, alarm, busy, seq_done, cur_slot,
                tmr_hour, tmr_min, tmr_sec, round_cnt, slot_valid};

  typedef struct {
    string       tag;
    logic [35:0] v;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic       e_ld = 0, e_rn = 0, e_al = 0, e_bz = 0, e_dn = 0;
  logic [1:0] e_slot = '0;
  logic [4:0] e_h = '0;
  logic [5:0] e_m = '0, e_s = '0;
  logic [7:0] e_rc = '0;
  logic [3:0] e_vld = '0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [35:0] exp_vec();
    return {e_ld, e_rn, e_al, e_bz, e_dn, e_slot, e_h, e_m, e_s, e_rc, e_vld};
  endfunction

  task automatic tick(input string tag);
    exp_t e;
    exp_q.push_back('{tag, exp_vec()});
    @(posedge clk_1Hz);
    #1;
    e = exp_q.pop_front();
    check_val(e.tag, 64'(obs), 64'(e.v));
  endtask

  task automatic ph(input logic ld, input logic rn, input logic al, input logic bz, input logic dn);
    e_ld = ld; e_rn = rn; e_al = al; e_bz = bz; e_dn = dn;
  endtask

  task automatic ph_idle();  ph(0, 0, 0, 0, 0); endtask
  task automatic ph_load();  ph(1, 0, 0, 1, 0); endtask
  task automatic ph_run();   ph(0, 1, 0, 1, 0); endtask
  task automatic ph_pause(); ph(0, 0, 0, 1, 0); endtask
  task automatic ph_alarm(); ph(0, 0, 1, 1, 0); endtask
  task automatic ph_done();  ph(0, 0, 0, 0, 1); endtask

  task automatic exp_preset(input logic [1:0] sl, input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    e_slot = sl; e_h = h; e_m = m; e_s = s;
  endtask

  task automatic write_slot(input logic [1:0] idx, input logic [4:0] h, input logic [5:0] m,
                            input logic [5:0] s, input logic [3:0] new_vld);
    prog_en = 1'b1; prog_wr = 1'b1;
    prog_slot = idx; prog_hour = h; prog_min = m; prog_sec = s;
    e_vld = new_vld;
    ph_idle();
    tick("prog_write");
    prog_wr = 1'b0;
    tick("prog_hold");
  endtask

  task automatic end_prog();
    prog_en = 1'b0;
    tick("prog_exit");
  endtask

  // One timer expiry: alarm holds ALARM_SECS cycles.
  task automatic alarm_phase(input string tag);
    tmr_zero = 1'b1;
    ph_alarm();
    tick(tag);
    tmr_zero = 1'b0;
    for (int k = 1; k < int'(ALARM_SECS); k++) tick(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12 resetn = 1'b1;
    tick("reset_state");

    // Two-slot sequence, no looping.
    write_slot(2'd0, 5'd0, 6'd0, 6'd5, 4'b0001);
    write_slot(2'd2, 5'd0, 6'd1, 6'd0, 4'b0101);
    end_prog();
    loop_en = 1'b0;
    run = 1'b1;
    ph_load(); exp_preset(2'd0, 5'd0, 6'd0, 6'd5);
    tick("s1_load0");
    ph_run();
    tick("s1_run0");
    tick("s1_run0");
    alarm_phase("s1_alarm0");
    ph_load(); exp_preset(2'd2, 5'd0, 6'd1, 6'd0);
    tick("s1_load2");
    ph_run();
    tick("s1_run2");
    alarm_phase("s1_alarm2");
    ph_done();
    tick("s1_done");
    tick("s1_done_hold");
    run = 1'b0;
    ph_idle();
    tick("s1_idle");

    // Clamping, clearing, pause/resume, abort beating tmr_zero.
    write_slot(2'd0, 5'd0, 6'd0, 6'd0, 4'b0100);
    write_slot(2'd2, 5'd0, 6'd0, 6'd0, 4'b0000);
    write_slot(2'd1, 5'd20, 6'd63, 6'd0, 4'b0010);
    end_prog();
    run = 1'b1;
    ph_load(); exp_preset(2'd1, 5'd12, 6'd59, 6'd0);
    tick("s2_load_clamped");
    ph_run();
    tick("s2_run");
    run = 1'b0;
    ph_pause();
    tick("s2_pause");
    tick("s2_pause_hold");
    run = 1'b1;
    ph_run();
    tick("s2_resume");
    abort = 1'b1; tmr_zero = 1'b1; run = 1'b0;
    ph_idle();
    tick("s2_abort_zero");
    abort = 1'b0; tmr_zero = 1'b0;
    tick("s2_idle");
    write_slot(2'd1, 5'd0, 6'd0, 6'd0, 4'b0000);
    end_prog();
    run = 1'b1;
    for (int k = 0; k < 4; k++) tick("s2_no_valid");
    run = 1'b0;
    tick("s2_idle_end");

    // Looping on a single slot, ignored busy write, round saturation.
    write_slot(2'd3, 5'd0, 6'd0, 6'd2, 4'b1000);
    end_prog();
    loop_en = 1'b1;
    run = 1'b1;
    ph_load(); exp_preset(2'd3, 5'd0, 6'd0, 6'd2); e_rc = 8'd0;
    tick("s3_load");
    ph_run();
    tick("s3_run");
    prog_en = 1'b1; prog_wr = 1'b1;
    prog_slot = 2'd0; prog_hour = 5'd0; prog_min = 6'd0; prog_sec = 6'd9;
    tick("s3_write_busy");
    prog_en = 1'b0; prog_wr = 1'b0;
    tick("s3_run_after_wr");
    for (int r = 1; r <= 256; r++) begin
      alarm_phase($sformatf("s3_alarm_r%0d", r));
      ph_load();
      e_rc = (r > 255) ? 8'd255 : 8'(r);
      tick($sformatf("s3_reload_r%0d", r));
      ph_run();
      tick($sformatf("s3_run_r%0d", r));
    end
    abort = 1'b1; run = 1'b0;
    ph_idle();
    tick("s3_abort");
    abort = 1'b0;
    tick("s3_idle");
    run = 1'b1;
    ph_load(); e_rc = 8'd0;
    tick("s3_restart_round_clr");
    ph_run();
    tick("s3_restart_run");
    tmr_zero = 1'b1;
    ph_alarm();
    tick("s3_alarm_before_rst");
    tmr_zero = 1'b0;

    // Asynchronous reset in the middle of an alarm.
    #2 resetn = 1'b0;
    #1 check_val("async_rst_outputs", 64'(obs), 64'd0);
    check_val("async_rst_alarm", 64'(alarm), 64'd0);
    #3 resetn = 1'b1;
    ph_idle(); exp_preset(2'd0, 5'd0, 6'd0, 6'd0); e_rc = 8'd0; e_vld = 4'b0000;
    tick("post_rst_idle");
    tick("post_rst_idle_hold");
    run = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
